perip_bridge: RTL and testbench

Memory-mapped responder on the CPU data port. It receives `perip_addr/wen/mask/wdata` from the core, decodes the address into data RAM or device registers, and merges byte-lane writes. It returns the full aligned read word on `perip_rdata` one cycle after the address. It sits beside the core inside the SoC, and the core performs load sign and zero extension.

---
 rtl/perip_pkg.sv | 58 +++++
 rtl/perip_dram.sv | 26 ++
 rtl/perip_bridge.sv | 161 ++++++++++++++++
 tb/tb_perip_bridge.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/perip_pkg.sv
// Shared constants and helpers for the CPU data-port bridge: address map,
// access-size encoding and byte-lane helpers.
package perip_pkg;

  localparam logic [31:0] DRAM_BASE       = 32'h8010_0000;
  localparam logic [31:0] SW_LO_ADDR      = 32'h8020_0000;
  localparam logic [31:0] SW_HI_ADDR      = 32'h8020_0004;
  localparam logic [31:0] SEG_ADDR        = 32'h8020_0020;
  localparam logic [31:0] LED_ADDR        = 32'h8020_0040;
  localparam logic [31:0] TIMER_CTRL_ADDR = 32'h8020_0050;
  localparam logic [31:0] TIMER_CNT_ADDR  = 32'h8020_0054;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } perip_size_e;

  function automatic logic [31:0] dram_span_bytes(input int words);
    return 32'(words) << 2;
  endfunction

  // Misaligned and reserved-size accesses yield no lanes, so they write nothing.
  function automatic logic [3:0] lane_en(input logic [1:0] mask, input logic [1:0] off);
    logic [3:0] en;
    en = 4'b0000;
    case (perip_size_e'(mask))
      SIZE_BYTE: en = 4'b0001 << off;
      SIZE_HALF: if (!off[0]) en = off[1] ? 4'b1100 : 4'b0011;
      SIZE_WORD: if (off == 2'b00) en = 4'b1111;
      default:   en = 4'b0000;
    endcase
    return en;
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0] mask, input logic [31:0] wdata);
    logic [31:0] d;
    case (perip_size_e'(mask))
      SIZE_BYTE: d = {4{wdata[7:0]}};
      SIZE_HALF: d = {2{wdata[15:0]}};
      default:   d = wdata;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] m;
    m = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) m[8*i +: 8] = new_word[8*i +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/perip_dram.sv
// Single-port data RAM, 32-bit words with byte write enables and a registered
// read-first output; no reset so it maps onto block RAM.
module perip_dram #(
  parameter int WORDS = 65536,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    rdata_q <= mem_q[addr];
    for (int i = 0; i < 4; i++) begin
      if (be[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/perip_bridge.sv
// Data-port responder: DRAM / MMIO decode, byte-lane writes, 1-cycle reads.
// Optional timer block is built only when PERIP_TIMER_EN is defined.
module perip_bridge
  import perip_pkg::*;
#(
  parameter int DRAM_WORDS = 65536,
  parameter int TIMER_DIV  = 100
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic [31:0] perip_addr,
  input  logic        perip_wen,
  input  logic [1:0]  perip_mask,
  input  logic [31:0] perip_wdata,
  output logic [31:0] perip_rdata,
  input  logic [63:0] virtual_sw,
  output logic [31:0] virtual_led,
  output logic [31:0] virtual_seg
);

  // No handshake: every cycle is one access; wen=1 commits on the next rising
  // edge, and the read word for the presented address is valid after that edge.

  localparam int AW = $clog2(DRAM_WORDS);

  if (TIMER_DIV < 1) begin : g_div_check
    $error("TIMER_DIV must be at least 1");
  end

  logic [29:0] word_addr;
  logic [3:0]  be;
  logic [31:0] wlane;
  logic        in_dram;
  logic        hit_sw_lo, hit_sw_hi, hit_seg, hit_led;
  logic [3:0]  dram_be;
  logic [31:0] dram_rdata;

  logic [31:0] led_q, led_d;
  logic [31:0] seg_q, seg_d;
  logic [63:0] sw_meta_q, sw_meta_d;
  logic [63:0] sw_sync_q, sw_sync_d;
  logic [31:0] mmio_rdata_q, mmio_rdata_d;
  logic        dram_sel_q, dram_sel_d;

  logic        timer_hit;
  logic [31:0] timer_rdata;

  // DRAM base is aligned to its span, so the upper bits alone select it.
  always_comb begin
    word_addr = perip_addr[31:2];
    in_dram   = perip_addr[31:AW+2] == DRAM_BASE[31:AW+2];
    hit_sw_lo = word_addr == SW_LO_ADDR[31:2];
    hit_sw_hi = word_addr == SW_HI_ADDR[31:2];
    hit_seg   = word_addr == SEG_ADDR[31:2];
    hit_led   = word_addr == LED_ADDR[31:2];
    be        = perip_wen ? lane_en(perip_mask, perip_addr[1:0]) : 4'b0000;
    wlane     = lane_data(perip_mask, perip_wdata);
    dram_be   = in_dram ? be : 4'b0000;
  end

  perip_dram #(
    .WORDS (DRAM_WORDS),
    .AW    (AW)
  ) u_dram (
    .clk   (cpu_clk),
    .addr  (perip_addr[AW+1:2]),
    .be    (dram_be),
    .wdata (wlane),
    .rdata (dram_rdata)
  );

`ifdef PERIP_TIMER_EN
  localparam int PW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TIMER_DIV - 1);

  logic          tctrl_q, tctrl_d;
  logic [31:0]   tcnt_q, tcnt_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          hit_tctrl, hit_tcnt;

  always_comb begin
    hit_tctrl = word_addr == TIMER_CTRL_ADDR[31:2];
    hit_tcnt  = word_addr == TIMER_CNT_ADDR[31:2];
    tctrl_d   = tctrl_q;
    tcnt_d    = tcnt_q;
    presc_d   = presc_q;
    if (hit_tctrl && be[0]) tctrl_d = wlane[0];
    if (tctrl_q) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        tcnt_d  = tcnt_q + 32'd1;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
    // A software load overrides any same-cycle tick.
    if (hit_tcnt && (|be)) begin
      tcnt_d  = merge_lanes(tcnt_q, wlane, be);
      presc_d = '0;
    end
    timer_hit   = hit_tctrl || hit_tcnt;
    timer_rdata = hit_tctrl ? {31'd0, tctrl_q} : tcnt_q;
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      tctrl_q <= 1'b0;
      tcnt_q  <= '0;
      presc_q <= '0;
    end else begin
      tctrl_q <= tctrl_d;
      tcnt_q  <= tcnt_d;
      presc_q <= presc_d;
    end
  end
`else
  always_comb begin
    timer_hit   = 1'b0;
    timer_rdata = '0;
  end
`endif

  always_comb begin
    led_d     = merge_lanes(led_q, wlane, hit_led ? be : 4'b0000);
    seg_d     = merge_lanes(seg_q, wlane, hit_seg ? be : 4'b0000);
    sw_meta_d = virtual_sw;
    sw_sync_d = sw_meta_q;
    // MMIO read captures pre-write register values, matching the RAM read-first port.
    mmio_rdata_d = '0;
    if (hit_sw_lo)      mmio_rdata_d = sw_sync_q[31:0];
    else if (hit_sw_hi) mmio_rdata_d = sw_sync_q[63:32];
    else if (hit_seg)   mmio_rdata_d = seg_q;
    else if (hit_led)   mmio_rdata_d = led_q;
    else if (timer_hit) mmio_rdata_d = timer_rdata;
    dram_sel_d = in_dram;
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      led_q        <= '0;
      seg_q        <= '0;
      sw_meta_q    <= '0;
      sw_sync_q    <= '0;
      mmio_rdata_q <= '0;
      dram_sel_q   <= 1'b0;
    end else begin
      led_q        <= led_d;
      seg_q        <= seg_d;
      sw_meta_q    <= sw_meta_d;
      sw_sync_q    <= sw_sync_d;
      mmio_rdata_q <= mmio_rdata_d;
      dram_sel_q   <= dram_sel_d;
    end
  end

  // Select is registered alongside the RAM output so both refer to the same access.
  assign perip_rdata = dram_sel_q ? dram_rdata : mmio_rdata_q;
  assign virtual_led = led_q;
  assign virtual_seg = seg_q;

endmodule

// File: tb/tb_perip_bridge.sv
// Directed self-checking bench for perip_bridge (1024-word DRAM, TIMER_DIV=4).
module tb_perip_bridge;
  import perip_pkg::*;

  localparam int DW = 1024;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst = 1'b0;
  logic [31:0] perip_addr = '0;
  logic        perip_wen = 1'b0;
  logic [1:0]  perip_mask = 2'b10;
  logic [31:0] perip_wdata = '0;
  logic [31:0] perip_rdata;
  logic [63:0] virtual_sw = '0;
  logic [31:0] virtual_led;
  logic [31:0] virtual_seg;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  perip_bridge #(
    .DRAM_WORDS (DW),
    .TIMER_DIV  (4)
  ) dut (
    .cpu_clk     (cpu_clk),
    .cpu_rst     (cpu_rst),
    .perip_addr  (perip_addr),
    .perip_wen   (perip_wen),
    .perip_mask  (perip_mask),
    .perip_wdata (perip_wdata),
    .perip_rdata (perip_rdata),
    .virtual_sw  (virtual_sw),
    .virtual_led (virtual_led),
    .virtual_seg (virtual_seg)
  );

  // ---------------- clock / reset ----------------
  always #5 cpu_clk = ~cpu_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic bus_write(input logic [31:0] a, input logic [1:0] m, input logic [31:0] d);
    @(negedge cpu_clk);
    perip_addr  = a;
    perip_mask  = m;
    perip_wdata = d;
    perip_wen   = 1'b1;
    @(negedge cpu_clk);
    perip_wen   = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] r);
    @(negedge cpu_clk);
    perip_addr = a;
    perip_wen  = 1'b0;
    @(posedge cpu_clk);
    #1;
    r = perip_rdata;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] r;
    if (perip_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=%h", perip_rdata, 32'h0); end
    checks++;
    if (virtual_led !== 32'h0) begin failures++; $display("FAIL reset_led got=%h exp=%h", virtual_led, 32'h0); end
    checks++;
    if (virtual_seg !== 32'h0) begin failures++; $display("FAIL reset_seg got=%h exp=%h", virtual_seg, 32'h0); end
    checks++;
    @(negedge cpu_clk);
    cpu_rst = 1'b1;
    bus_read(TIMER_CTRL_ADDR, r);
    if (r !== 32'h0) begin failures++; $display("FAIL reset_tctrl got=%h exp=%h", r, 32'h0); end
    checks++;
    bus_read(TIMER_CNT_ADDR, r);
    if (r !== 32'h0) begin failures++; $display("FAIL reset_tcnt got=%h exp=%h", r, 32'h0); end
    checks++;
  endtask

  task automatic test_word_rw();
    logic [31:0] r;
    bus_write(32'h8010_0008, 2'b10, 32'hDEAD_BEEF);
    bus_read(32'h8010_0008, r);
    if (r !== 32'hDEAD_BEEF) begin failures++; $display("FAIL word_rw got=%h exp=%h", r, 32'hDEAD_BEEF); end
    checks++;
    // last word of the RAM, then the first address past it
    bus_write(32'h8010_0FFC, 2'b10, 32'h5A5A_0001);
    bus_read(32'h8010_0FFC, r);
    if (r !== 32'h5A5A_0001) begin failures++; $display("FAIL dram_last got=%h exp=%h", r, 32'h5A5A_0001); end
    checks++;
    bus_write(32'h8010_0000, 2'b10, 32'h1111_1111);
    bus_write(32'h8010_1000, 2'b10, 32'h2222_2222);
    bus_read(32'h8010_1000, r);
    if (r !== 32'h0) begin failures++; $display("FAIL dram_past_end got=%h exp=%h", r, 32'h0); end
    checks++;
    bus_read(32'h8010_0000, r);
    if (r !== 32'h1111_1111) begin failures++; $display("FAIL dram_no_alias got=%h exp=%h", r, 32'h1111_1111); end
    checks++;
  endtask

  task automatic test_merge();
    logic [31:0] r;
    bus_write(32'h8010_0008, 2'b10, 32'h00EF_0000);
    bus_write(32'h8010_000B, 2'b00, 32'h0000_00AA);
    bus_write(32'h8010_0008, 2'b01, 32'h0000_1234);
    bus_read(32'h8010_0008, r);
    if (r !== 32'hAAEF_1234) begin failures++; $display("FAIL merge_byte_half got=%h exp=%h", r, 32'hAAEF_1234); end
    checks++;
    bus_write(32'h8010_0009, 2'b00, 32'hFFFF_FF55);
    bus_read(32'h8010_0008, r);
    if (r !== 32'hAAEF_5534) begin failures++; $display("FAIL merge_byte1 got=%h exp=%h", r, 32'hAAEF_5534); end
    checks++;
    bus_write(32'h8010_000A, 2'b01, 32'hBEEF_7788);
    bus_read(32'h8010_0008, r);
    if (r !== 32'h7788_5534) begin failures++; $display("FAIL merge_half_hi got=%h exp=%h", r, 32'h7788_5534); end
    checks++;
  endtask

  task automatic test_misaligned_unmapped();
    logic [31:0] r;
    bus_write(32'h8010_0009, 2'b10, 32'h1234_5678);
    bus_write(32'h8010_000B, 2'b01, 32'h0000_FFFF);
    bus_write(32'h8010_0008, 2'b11, 32'h0BAD_0BAD);
    bus_read(32'h8010_0008, r);
    if (r !== 32'h7788_5534) begin failures++; $display("FAIL misaligned_drop got=%h exp=%h", r, 32'h7788_5534); end
    checks++;
    bus_read(32'h8010_000B, r);
    if (r !== 32'h7788_5534) begin failures++; $display("FAIL misaligned_read got=%h exp=%h", r, 32'h7788_5534); end
    checks++;
    bus_write(32'h8030_0000, 2'b10, 32'hFFFF_FFFF);
    bus_read(32'h8030_0000, r);
    if (r !== 32'h0) begin failures++; $display("FAIL unmapped_read got=%h exp=%h", r, 32'h0); end
    checks++;
  endtask

  task automatic test_mmio();
    logic [31:0] r;
    bus_write(LED_ADDR, 2'b10, 32'h0000_0005);
    if (virtual_led !== 32'h5) begin failures++; $display("FAIL led_word got=%h exp=%h", virtual_led, 32'h5); end
    checks++;
    bus_write(SEG_ADDR + 32'd1, 2'b00, 32'h0000_007F);
    if (virtual_seg !== 32'h0000_7F00) begin failures++; $display("FAIL seg_byte got=%h exp=%h", virtual_seg, 32'h0000_7F00); end
    checks++;
    bus_read(SEG_ADDR, r);
    if (r !== 32'h0000_7F00) begin failures++; $display("FAIL seg_read got=%h exp=%h", r, 32'h0000_7F00); end
    checks++;
    bus_write(LED_ADDR + 32'd2, 2'b01, 32'h0000_ABCD);
    bus_write(LED_ADDR + 32'd1, 2'b01, 32'h0000_9999);
    if (virtual_led !== 32'hABCD_0005) begin failures++; $display("FAIL led_half got=%h exp=%h", virtual_led, 32'hABCD_0005); end
    checks++;
  endtask

  task automatic test_switches();
    logic [31:0] r;
    @(negedge cpu_clk);
    virtual_sw = 64'h0000_0001_0000_0002;
    bus_read(SW_LO_ADDR, r);
    if (r !== 32'h0) begin failures++; $display("FAIL sw_sync_latency got=%h exp=%h", r, 32'h0); end
    checks++;
    bus_read(SW_LO_ADDR, r);
    if (r !== 32'h2) begin failures++; $display("FAIL sw_lo got=%h exp=%h", r, 32'h2); end
    checks++;
    bus_read(SW_HI_ADDR, r);
    if (r !== 32'h1) begin failures++; $display("FAIL sw_hi got=%h exp=%h", r, 32'h1); end
    checks++;
    bus_write(SW_LO_ADDR, 2'b10, 32'hFFFF_FFFF);
    bus_read(SW_LO_ADDR, r);
    if (r !== 32'h2) begin failures++; $display("FAIL sw_readonly got=%h exp=%h", r, 32'h2); end
    checks++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    logic [31:0] e;
    logic [31:0] addrs [4];
    bus_write(32'h8010_0010, 2'b10, 32'h0102_0304);
    // second write to the same word returns the pre-write contents
    @(negedge cpu_clk);
    perip_addr  = 32'h8010_0010;
    perip_mask  = 2'b10;
    perip_wdata = 32'h0A0B_0C0D;
    perip_wen   = 1'b1;
    @(posedge cpu_clk);
    #1;
    r = perip_rdata;
    if (r !== 32'h0102_0304) begin failures++; $display("FAIL read_during_write got=%h exp=%h", r, 32'h0102_0304); end
    checks++;
    @(negedge cpu_clk);
    perip_wen  = 1'b0;
    @(posedge cpu_clk);
    #1;
    r = perip_rdata;
    if (r !== 32'h0A0B_0C0D) begin failures++; $display("FAIL write_then_read got=%h exp=%h", r, 32'h0A0B_0C0D); end
    checks++;
    addrs = '{32'h8010_0008, LED_ADDR, 32'h8010_0010, 32'h8030_0000};
    exp_q.push_back(32'h7788_5534);
    exp_q.push_back(32'hABCD_0005);
    exp_q.push_back(32'h0A0B_0C0D);
    exp_q.push_back(32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge cpu_clk);
      perip_addr = addrs[i];
      @(posedge cpu_clk);
      #1;
      e = exp_q.pop_front();
      if (perip_rdata !== e) begin failures++; $display("FAIL pipelined_read%0d got=%h exp=%h", i, perip_rdata, e); end
      checks++;
    end
  endtask

  task automatic test_timer();
    logic [31:0] r;
`ifdef PERIP_TIMER_EN
    bus_write(TIMER_CTRL_ADDR, 2'b10, 32'hFFFF_FFFF);
    repeat (40) @(posedge cpu_clk);
    bus_read(TIMER_CNT_ADDR, r);
    if (r !== 32'd10) begin failures++; $display("FAIL timer_count got=%h exp=%h", r, 32'd10); end
    checks++;
    bus_read(TIMER_CTRL_ADDR, r);
    if (r !== 32'h1) begin failures++; $display("FAIL timer_ctrl_read got=%h exp=%h", r, 32'h1); end
    checks++;
    bus_write(TIMER_CNT_ADDR, 2'b10, 32'hFFFF_FFFF);
    repeat (3) @(posedge cpu_clk);
    bus_read(TIMER_CNT_ADDR, r);
    if (r !== 32'hFFFF_FFFF) begin failures++; $display("FAIL timer_load got=%h exp=%h", r, 32'hFFFF_FFFF); end
    checks++;
    bus_read(TIMER_CNT_ADDR, r);
    if (r !== 32'h0) begin failures++; $display("FAIL timer_wrap got=%h exp=%h", r, 32'h0); end
    checks++;
    bus_write(TIMER_CTRL_ADDR, 2'b10, 32'h0);
    bus_write(TIMER_CNT_ADDR, 2'b10, 32'h5);
    bus_write(TIMER_CNT_ADDR + 32'd3, 2'b00, 32'h80);
    repeat (20) @(posedge cpu_clk);
    bus_read(TIMER_CNT_ADDR, r);
    if (r !== 32'h8000_0005) begin failures++; $display("FAIL timer_frozen got=%h exp=%h", r, 32'h8000_0005); end
    checks++;
`else
    bus_write(TIMER_CTRL_ADDR, 2'b10, 32'h1);
    bus_write(TIMER_CNT_ADDR, 2'b10, 32'h1234);
    repeat (10) @(posedge cpu_clk);
    bus_read(TIMER_CNT_ADDR, r);
    if (r !== 32'h0) begin failures++; $display("FAIL timer_absent_cnt got=%h exp=%h", r, 32'h0); end
    checks++;
    bus_read(TIMER_CTRL_ADDR, r);
    if (r !== 32'h0) begin failures++; $display("FAIL timer_absent_ctrl got=%h exp=%h", r, 32'h0); end
    checks++;
`endif
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    bus_write(LED_ADDR, 2'b10, 32'h33);
    bus_write(SEG_ADDR, 2'b10, 32'h44);
    bus_write(TIMER_CTRL_ADDR, 2'b10, 32'h1);
    bus_read(LED_ADDR, r);
    if (r !== 32'h33) begin failures++; $display("FAIL pre_reset_led got=%h exp=%h", r, 32'h33); end
    checks++;
    @(negedge cpu_clk);
    perip_addr  = LED_ADDR;
    perip_mask  = 2'b10;
    perip_wdata = 32'h99;
    perip_wen   = 1'b1;
    #2;
    cpu_rst = 1'b0;
    #1;
    if ({virtual_led, virtual_seg, perip_rdata} !== 96'h0) begin
      failures++;
      $display("FAIL async_reset got=%h/%h/%h exp=0/0/0", virtual_led, virtual_seg, perip_rdata);
    end
    checks++;
    @(posedge cpu_clk);
    #1;
    if (virtual_led !== 32'h0) begin failures++; $display("FAIL reset_drops_write got=%h exp=%h", virtual_led, 32'h0); end
    checks++;
    @(negedge cpu_clk);
    perip_wen = 1'b0;
    cpu_rst   = 1'b1;
    bus_read(LED_ADDR, r);
    if (r !== 32'h0) begin failures++; $display("FAIL post_reset_led got=%h exp=%h", r, 32'h0); end
    checks++;
    bus_read(TIMER_CTRL_ADDR, r);
    if (r !== 32'h0) begin failures++; $display("FAIL post_reset_tctrl got=%h exp=%h", r, 32'h0); end
    checks++;
    repeat (10) @(posedge cpu_clk);
    bus_read(TIMER_CNT_ADDR, r);
    if (r !== 32'h0) begin failures++; $display("FAIL post_reset_tcnt got=%h exp=%h", r, 32'h0); end
    checks++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    repeat (3) @(posedge cpu_clk);
    #1;
    test_reset();
    test_word_rw();
    test_merge();
    test_misaligned_unmapped();
    test_mmio();
    test_switches();
    test_back_to_back();
    test_timer();
    test_reset_mid();
    repeat (2) @(posedge cpu_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
